// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: update-op encodings and widths.
package register_file_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

endpackage

// File: rtl/clock_enable_divider.sv
// Free-running divider producing a one-clk enable pulse every DIV_RATIO cycles.
module clock_enable_divider #(
  parameter int unsigned DIV_RATIO = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_RATIO - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (count_q == LAST) count_d = '0;
  end

  // tick is registered alongside the count so it is high exactly while count == LAST
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tick    <= 1'b0;
    end else begin
      count_q <= count_d;
      tick    <= (count_d == LAST);
    end
  end

endmodule

// File: rtl/register_file_top.sv
// Bank of update-able registers sharing one tri-state data bus, stepped by a clock-enable tick.
module register_file_top
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned DIV_RATIO   = 4,
  parameter int unsigned RESET_VALUE = 0,
  localparam int unsigned AW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  oe,
  input  logic                  latch,
  input  logic [OP_W-1:0]       op,
  input  logic [AW-1:0]         wsel,
  input  logic [AW-1:0]         rsel,
  inout  tri logic [DATA_WIDTH-1:0] data_bus,
  output logic [DATA_WIDTH-1:0] register_state,
  output logic                  tick
);

  localparam logic [AW:0] NREGS = (AW + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_val_c;
  logic [DATA_WIDTH-1:0] wr_cur_c;
  logic [DATA_WIDTH-1:0] wr_val_c;
  logic                  wsel_ok_c;
  logic                  rsel_ok_c;
  logic                  drive_c;

  clock_enable_divider #(
    .DIV_RATIO(DIV_RATIO)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign wsel_ok_c = ({1'b0, wsel} < NREGS);
  assign rsel_ok_c = ({1'b0, rsel} < NREGS);

  // Selected-register reads; unpopulated addresses read as zero
  always_comb begin
    rd_val_c = '0;
    wr_cur_c = '0;
    if (rsel_ok_c) rd_val_c = regs_q[rsel];
    if (wsel_ok_c) wr_cur_c = regs_q[wsel];
  end

  // Update mux; INC/DEC wrap naturally at DATA_WIDTH
  always_comb begin
    wr_val_c = wr_cur_c;
    case (op_e'(op))
      OP_LOAD: wr_val_c = data_bus;
      OP_INC:  wr_val_c = wr_cur_c + DATA_WIDTH'(1);
      OP_DEC:  wr_val_c = wr_cur_c - DATA_WIDTH'(1);
      OP_CLR:  wr_val_c = '0;
      default: wr_val_c = wr_cur_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= DATA_WIDTH'(RESET_VALUE);
    end else if (tick && latch && wsel_ok_c) begin
      regs_q[wsel] <= wr_val_c;
    end
  end

  // latch wins over oe so an external source can LOAD while oe stays high
  assign drive_c        = oe && !latch;
  assign data_bus       = drive_c ? rd_val_c : {DATA_WIDTH{1'bz}};
  assign register_state = rd_val_c;

endmodule
